// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: access size encodings,
// arbiter state names and the size/load-extension helpers.
package dmem_pkg;

    localparam logic [1:0] SIZE_B   = 2'b00;
    localparam logic [1:0] SIZE_H   = 2'b01;
    localparam logic [1:0] SIZE_W   = 2'b10;
    localparam logic [1:0] SIZE_ILL = 2'b11;

    // The arbiter state is never stored; it is derived from the starvation counter.
    typedef enum logic {
        ARB_NORMAL = 1'b0,
        ARB_FORCE1 = 1'b1
    } arb_state_e;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SIZE_B:  n = 3'd1;
            SIZE_H:  n = 3'd2;
            SIZE_W:  n = 3'd4;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

    function automatic logic [31:0] load_extend(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] r;
        case (size)
            SIZE_B:  r = {24'b0, data[7:0]};
            SIZE_H:  r = {16'b0, data[15:0]};
            SIZE_W:  r = data;
            default: r = 32'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_rsp_slot.sv
// Per-master response register: turns a grant into a one-cycle rvalid pulse
// carrying the error flag and zero-extended load data.
module dmem_rsp_slot (
    input  logic        clk,
    input  logic        rst,
    input  logic        gnt,
    input  logic        ok,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic [31:0] mem_rdata,
    output logic        rvalid,
    output logic        err,
    output logic [31:0] rdata
);
    import dmem_pkg::*;

    // Stores and rejected accesses return zero data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rvalid <= 1'b0;
            err    <= 1'b0;
            rdata  <= 32'b0;
        end else begin
            rvalid <= gnt;
            err    <= gnt & ~ok;
            rdata  <= (gnt && ok && !we) ? load_extend(size, mem_rdata) : 32'b0;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter: m0 has fixed priority, m1 is guaranteed
// a grant after STARVE_LIMIT consecutive lost cycles.
module dmem_arbiter #(
    parameter int DROM_SPACE   = 1024,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_we,
    input  logic [1:0]  m0_size,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_we,
    input  logic [1:0]  m1_size,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_r_en,
    output logic        mem_w_en,
    output logic [1:0]  mem_byte_sel,
    input  logic [31:0] mem_rdata
);
    import dmem_pkg::*;

    localparam logic [7:0]  LIMIT      = 8'(STARVE_LIMIT);
    localparam logic [32:0] DROM_LIMIT = 33'(DROM_SPACE);

    // The end address is formed in 33 bits so accesses near 0xFFFFFFFF cannot wrap into range.
    function automatic logic access_ok(input logic [31:0] addr, input logic [1:0] size);
        logic [32:0] end_addr;
        end_addr = {1'b0, addr} + {30'b0, size_bytes(size)};
        return (size != SIZE_ILL) && (end_addr <= DROM_LIMIT);
    endfunction

    logic [7:0] wait_cnt;
    arb_state_e arb_state;
    logic       force1;
    logic       sel1;
    logic       m0_ok;
    logic       m1_ok;
    logic       sel_we;
    logic       sel_ok;

    assign m0_ok = access_ok(m0_addr, m0_size);
    assign m1_ok = access_ok(m1_addr, m1_size);

    assign arb_state = (wait_cnt == LIMIT) ? ARB_FORCE1 : ARB_NORMAL;
    assign force1    = (arb_state == ARB_FORCE1);

    assign sel1   = m1_req && (!m0_req || force1);
    assign m0_gnt = rst && m0_req && !sel1;
    assign m1_gnt = rst && sel1;

    // Ungranted cycles leave the memory port fully quiet, including the address.
    always_comb begin
        mem_addr     = 32'b0;
        mem_wdata    = 32'b0;
        mem_byte_sel = 2'b00;
        sel_we       = 1'b0;
        sel_ok       = 1'b0;
        if (m0_gnt) begin
            mem_addr     = m0_addr;
            mem_wdata    = m0_wdata;
            mem_byte_sel = m0_size;
            sel_we       = m0_we;
            sel_ok       = m0_ok;
        end else if (m1_gnt) begin
            mem_addr     = m1_addr;
            mem_wdata    = m1_wdata;
            mem_byte_sel = m1_size;
            sel_we       = m1_we;
            sel_ok       = m1_ok;
        end
    end

    assign mem_w_en = sel_we & sel_ok;
    assign mem_r_en = ~sel_we & sel_ok;

    // FORCE1 is left after exactly one m1 grant because the grant clears the count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt <= 8'd0;
        end else if (!m1_req || m1_gnt) begin
            wait_cnt <= 8'd0;
        end else if (wait_cnt < LIMIT) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    dmem_rsp_slot u_rsp0 (
        .clk       (clk),
        .rst       (rst),
        .gnt       (m0_gnt),
        .ok        (m0_ok),
        .we        (m0_we),
        .size      (m0_size),
        .mem_rdata (mem_rdata),
        .rvalid    (m0_rvalid),
        .err       (m0_err),
        .rdata     (m0_rdata)
    );

    dmem_rsp_slot u_rsp1 (
        .clk       (clk),
        .rst       (rst),
        .gnt       (m1_gnt),
        .ok        (m1_ok),
        .we        (m1_we),
        .size      (m1_size),
        .mem_rdata (mem_rdata),
        .rvalid    (m1_rvalid),
        .err       (m1_err),
        .rdata     (m1_rdata)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a little-endian byte memory model
// standing in for data_memory.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    logic        clk;
    logic        rst;
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_we, m1_we;
    logic [1:0]  m0_size, m1_size;
    logic        m0_gnt, m1_gnt;
    logic        m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_err, m1_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [1:0]  mem_byte_sel;
    logic [31:0] mem_rdata;

    logic [7:0]  tb_mem [0:1023];
    logic [9:0]  ra;

    int total = 0;
    int bad   = 0;

    dmem_arbiter #(.DROM_SPACE(1024), .STARVE_LIMIT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .m0_req       (m0_req),
        .m0_addr      (m0_addr),
        .m0_wdata     (m0_wdata),
        .m0_we        (m0_we),
        .m0_size      (m0_size),
        .m0_gnt       (m0_gnt),
        .m0_rvalid    (m0_rvalid),
        .m0_rdata     (m0_rdata),
        .m0_err       (m0_err),
        .m1_req       (m1_req),
        .m1_addr      (m1_addr),
        .m1_wdata     (m1_wdata),
        .m1_we        (m1_we),
        .m1_size      (m1_size),
        .m1_gnt       (m1_gnt),
        .m1_rvalid    (m1_rvalid),
        .m1_rdata     (m1_rdata),
        .m1_err       (m1_err),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_r_en     (mem_r_en),
        .mem_w_en     (mem_w_en),
        .mem_byte_sel (mem_byte_sel),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational little-endian read, byte write at the clock edge.
    assign ra = mem_addr[9:0];
    always_comb begin
        mem_rdata = {tb_mem[ra + 10'd3], tb_mem[ra + 10'd2], tb_mem[ra + 10'd1], tb_mem[ra]};
    end

    always @(posedge clk) begin
        if (mem_w_en) begin
            tb_mem[ra] <= mem_wdata[7:0];
            if (mem_byte_sel != SIZE_B) tb_mem[ra + 10'd1] <= mem_wdata[15:8];
            if (mem_byte_sel == SIZE_W) begin
                tb_mem[ra + 10'd2] <= mem_wdata[23:16];
                tb_mem[ra + 10'd3] <= mem_wdata[31:24];
            end
        end
    end

    task automatic applyStimulus(input int master, input logic req, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic we, input logic [1:0] size);
        if (master == 0) begin
            m0_req = req; m0_addr = addr; m0_wdata = wdata; m0_we = we; m0_size = size;
        end else begin
            m1_req = req; m1_addr = addr; m1_wdata = wdata; m1_we = we; m1_size = size;
        end
    endtask

    task automatic idle();
        applyStimulus(0, 1'b0, 32'h0, 32'h0, 1'b0, SIZE_B);
        applyStimulus(1, 1'b0, 32'h0, 32'h0, 1'b0, SIZE_B);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0;
        applyStimulus(0, 1'b1, 32'h10, 32'h0, 1'b0, SIZE_W);
        applyStimulus(1, 1'b1, 32'h20, 32'h0, 1'b0, SIZE_W);
        tick();
        tick();
        $display("[TB] reset state");
        checkOutput("rst_m0_gnt", 32'(m0_gnt), 32'h0);
        checkOutput("rst_m1_gnt", 32'(m1_gnt), 32'h0);
        checkOutput("rst_r_en", 32'(mem_r_en), 32'h0);
        checkOutput("rst_m0_rvalid", 32'(m0_rvalid), 32'h0);
        checkOutput("rst_m1_rvalid", 32'(m1_rvalid), 32'h0);
        checkOutput("rst_m0_rdata", m0_rdata, 32'h0);
        checkOutput("rst_wait_cnt", 32'(dut.wait_cnt), 32'h0);

        $display("[TB] m0 store then loads");
        idle();
        rst = 1'b1;
        applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1, SIZE_W);
        #1;
        checkOutput("st_gnt", 32'(m0_gnt), 32'h1);
        checkOutput("st_w_en", 32'(mem_w_en), 32'h1);
        checkOutput("st_r_en", 32'(mem_r_en), 32'h0);
        checkOutput("st_addr", mem_addr, 32'h10);
        checkOutput("st_wdata", mem_wdata, 32'hDEADBEEF);
        checkOutput("st_bsel", 32'(mem_byte_sel), 32'h2);
        tick();
        checkOutput("st_rvalid", 32'(m0_rvalid), 32'h1);
        checkOutput("st_err", 32'(m0_err), 32'h0);
        checkOutput("st_rdata", m0_rdata, 32'h0);
        applyStimulus(0, 1'b1, 32'h10, 32'h0, 1'b0, SIZE_W);
        #1;
        checkOutput("ldw_gnt", 32'(m0_gnt), 32'h1);
        checkOutput("ldw_r_en", 32'(mem_r_en), 32'h1);
        tick();
        checkOutput("ldw_rvalid", 32'(m0_rvalid), 32'h1);
        checkOutput("ldw_err", 32'(m0_err), 32'h0);
        checkOutput("ldw_rdata", m0_rdata, 32'hDEADBEEF);
        applyStimulus(0, 1'b1, 32'h11, 32'h0, 1'b0, SIZE_B);
        tick();
        checkOutput("ldb_rvalid", 32'(m0_rvalid), 32'h1);
        checkOutput("ldb_rdata", m0_rdata, 32'h000000BE);
        applyStimulus(0, 1'b1, 32'h12, 32'h0, 1'b0, SIZE_H);
        tick();
        checkOutput("ldh_rdata", m0_rdata, 32'h0000DEAD);
        idle();
        #1;
        checkOutput("idle_gnt", 32'(m0_gnt), 32'h0);
        checkOutput("idle_addr", mem_addr, 32'h0);
        tick();
        checkOutput("pulse_end", 32'(m0_rvalid), 32'h0);

        $display("[TB] m1 range boundary");
        applyStimulus(1, 1'b1, 32'd1020, 32'h44332211, 1'b1, SIZE_W);
        tick();
        checkOutput("m1_st_err", 32'(m1_err), 32'h0);
        applyStimulus(1, 1'b1, 32'd1021, 32'h0, 1'b0, SIZE_W);
        #1;
        checkOutput("rng_gnt", 32'(m1_gnt), 32'h1);
        checkOutput("rng_r_en", 32'(mem_r_en), 32'h0);
        tick();
        checkOutput("rng_rvalid", 32'(m1_rvalid), 32'h1);
        checkOutput("rng_err", 32'(m1_err), 32'h1);
        checkOutput("rng_rdata", m1_rdata, 32'h0);
        applyStimulus(1, 1'b1, 32'd1020, 32'h0, 1'b0, SIZE_W);
        #1;
        checkOutput("edge_r_en", 32'(mem_r_en), 32'h1);
        tick();
        checkOutput("edge_err", 32'(m1_err), 32'h0);
        checkOutput("edge_rdata", m1_rdata, 32'h44332211);
        applyStimulus(1, 1'b1, 32'd1023, 32'h0, 1'b0, SIZE_B);
        tick();
        checkOutput("lastb_err", 32'(m1_err), 32'h0);
        checkOutput("lastb_rdata", m1_rdata, 32'h00000044);

        $display("[TB] illegal size store");
        idle();
        applyStimulus(0, 1'b1, 32'h20, 32'h12345678, 1'b1, SIZE_W);
        tick();
        applyStimulus(0, 1'b1, 32'h20, 32'hCAFEF00D, 1'b1, SIZE_ILL);
        #1;
        checkOutput("ill_gnt", 32'(m0_gnt), 32'h1);
        checkOutput("ill_w_en", 32'(mem_w_en), 32'h0);
        checkOutput("ill_r_en", 32'(mem_r_en), 32'h0);
        tick();
        checkOutput("ill_rvalid", 32'(m0_rvalid), 32'h1);
        checkOutput("ill_err", 32'(m0_err), 32'h1);
        checkOutput("ill_rdata", m0_rdata, 32'h0);
        applyStimulus(0, 1'b1, 32'h20, 32'h0, 1'b0, SIZE_W);
        tick();
        checkOutput("old_err", 32'(m0_err), 32'h0);
        checkOutput("old_rdata", m0_rdata, 32'h12345678);
        idle();
        tick();

        $display("[TB] starvation");
        applyStimulus(0, 1'b1, 32'h10, 32'h0, 1'b0, SIZE_W);
        applyStimulus(1, 1'b1, 32'h20, 32'h0, 1'b0, SIZE_W);
        for (int k = 0; k < 10; k++) begin
            #1;
            checkOutput("starve_m1_gnt", 32'(k % 5 == 4), 32'(m1_gnt) ^ 32'h0);
            checkOutput("starve_m0_gnt", 32'(m0_gnt), 32'(k % 5 != 4));
            checkOutput("starve_wait", 32'(dut.wait_cnt), 32'(k % 5));
            tick();
        end
        checkOutput("starve_wait_clr", 32'(dut.wait_cnt), 32'h0);
        idle();
        tick();

        $display("[TB] reset mid-access");
        applyStimulus(0, 1'b1, 32'h10, 32'h0, 1'b0, SIZE_W);
        applyStimulus(1, 1'b1, 32'h20, 32'h0, 1'b0, SIZE_W);
        #1;
        checkOutput("mid_gnt_pre", 32'(m0_gnt), 32'h1);
        rst = 1'b0;
        #1;
        checkOutput("mid_m0_gnt", 32'(m0_gnt), 32'h0);
        checkOutput("mid_m1_gnt", 32'(m1_gnt), 32'h0);
        checkOutput("mid_r_en", 32'(mem_r_en), 32'h0);
        tick();
        checkOutput("mid_rvalid", 32'(m0_rvalid), 32'h0);
        checkOutput("mid_wait", 32'(dut.wait_cnt), 32'h0);
        tick();
        checkOutput("mid_m1_gnt2", 32'(m1_gnt), 32'h0);
        rst = 1'b1;
        #1;
        checkOutput("post_m0_gnt", 32'(m0_gnt), 32'h1);
        checkOutput("post_m1_gnt", 32'(m1_gnt), 32'h0);
        tick();
        checkOutput("post_rvalid", 32'(m0_rvalid), 32'h1);
        checkOutput("post_rdata", m0_rdata, 32'hDEADBEEF);
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single byte-addressed data memory between two masters:
  - m0: core MEM stage, normally has priority.
  - m1: secondary master (debug/DMA loader).
- m0 has fixed priority. A starvation counter guarantees m1 forward progress.
- Grants one access per cycle and drives the memory port. Returns a registered response (read data or write ack) one cycle after grant.
- Sits between the pipeline MEM stage and data_memory.

Parameters:
- DROM_SPACE, 1024, memory size in bytes; used for the range check.
- STARVE_LIMIT, 4, consecutive lost m1 cycles before m1 is forced priority (legal range 1-255).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-low.
- m0_req / m1_req  in  1  access request; held with payload stable until gnt.
- m0_addr / m1_addr  in  32  byte address.
- m0_wdata / m1_wdata  in  32  store data, LSB-aligned.
- m0_we / m1_we  in  1  1=store, 0=load.
- m0_size / m1_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- m0_gnt / m1_gnt  out  1  combinational grant; the access occurs this cycle.
- m0_rvalid / m1_rvalid  out  1  response valid, registered.
- m0_rdata / m1_rdata  out  32  load data, zero-extended per size; 0 for stores and errors.
- m0_err / m1_err  out  1  qualifies rvalid; illegal size or out of range.
- mem_addr  out  32  to data_memory data_addr.
- mem_wdata  out  32  to w_data_mem.
- mem_r_en  out  1  to r_en_mem.
- mem_w_en  out  1  to w_en_mem.
- mem_byte_sel  out  2  to byte_sel.
- mem_rdata  in  32  from r_data_mem (combinational).

Behaviour:
- Reset: rst=0 at posedge clears all rvalid/err/rdata to 0 and wait_cnt to 0. While rst=0, gnt, mem_r_en and mem_w_en are forced 0.
- Arbitration, combinational each cycle:
  - force1 = (wait_cnt == STARVE_LIMIT).
  - Both requesting: m0 wins unless force1.
  - Single requester: always wins.
  - No request: no grant; mem_r_en = mem_w_en = 0; mem_addr/wdata/byte_sel = 0.
- Memory drive for the granted master:
  - mem_addr = addr, mem_wdata = wdata, mem_byte_sel = size.
  - mem_w_en = we & ok; mem_r_en = ~we & ok. Never both high.
  - ok = (size != 11) && (addr + nbytes <= DROM_SPACE), with nbytes = 1/2/4 and the sum computed in 33 bits so there is no wrap at 0xFFFFFFFF.
  - ok=0: gnt is still asserted but no memory access occurs.
- Response, latency 1: on posedge after gnt, the granted master gets rvalid=1 and err=~ok.
  - Load rdata: byte = {24'b0, mem_rdata[7:0]}; half = {16'b0, mem_rdata[15:0]}; word = mem_rdata.
  - Store or err: rdata = 0.
  - rvalid is a single-cycle pulse, cleared the next cycle unless granted again.
  - Back-to-back grants to the same master give rvalid on consecutive cycles.
- Store timing: the memory byte write lands at the grant posedge. A load granted the next cycle sees the new data.
- Starvation counter wait_cnt, 8 bits:
  - Increments when m1_req & ~m1_gnt, saturating at STARVE_LIMIT.
  - Clears to 0 when m1_gnt or ~m1_req.
- States are implicit in wait_cnt: NORMAL (wait_cnt < LIMIT) and FORCE1 (== LIMIT). FORCE1 lasts exactly one grant, then returns to NORMAL.
- Masters drop req the cycle after gnt unless issuing a new access. Arbiter behaviour for a req that changes payload before gnt is undefined.
- Reset mid-access: a response pending at the reset edge is discarded. A store granted the cycle before reset has already completed.

Decomposition:
- Package dmem_pkg:
  - SIZE_B = 2'b00, SIZE_H = 2'b01, SIZE_W = 2'b10, SIZE_ILL = 2'b11.
  - Function size_bytes(size).
  - Function load_extend(size, data).
- One sub-module, dmem_rsp_slot, instantiated per master: registers rvalid/err/rdata from the gnt, ok, we, size and mem_rdata inputs.
- The top level holds the arbitration, wait_cnt and the memory mux.

Test Plan:
- m0 word store addr 0x10 data 0xDEADBEEF, then word load 0x10 → m0_gnt both cycles; rvalid 1 cycle later each; load rdata = 0xDEADBEEF, err = 0.
- Byte load 0x11 after the above → rdata = 0x000000BE. Half load 0x12 → rdata = 0x0000DEAD.
- m0 and m1 both requesting continuously, STARVE_LIMIT = 4 → m1 granted on every 5th cycle; wait_cnt returns to 0 after each m1 grant; m0 gets all other cycles.
- m1 word load at addr 1021 (DROM_SPACE = 1024) → gnt = 1, mem_r_en = 0, next cycle m1_rvalid = 1, m1_err = 1, rdata = 0. Addr 1020 → err = 0.
- size = 11 store from m0 at 0x20 → no mem_w_en, m0_err = 1; a later load of 0x20 returns the old contents.
- rst = 0 asserted the cycle after an m0 load gnt → m0_rvalid stays 0, wait_cnt = 0, gnt = 0 while rst = 0. After rst = 1, the first request is granted normally.
